// File: rtl/cp0_regs_pkg.sv
// cp0_defs: shared CP0 register numbers, exception codes and write masks.
package cp0_defs;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // Exception types that enter the handler (everything except eret).
    function automatic logic is_trap(input logic [31:0] t);
        return t inside {EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV};
    endfunction
endpackage

// File: rtl/cp0_regs_timer.sv
// cp0_timer: half-rate Count, Compare and sticky timer interrupt.
//   clk, rst (async active-low)
//   count_we/compare_we/wdata : mtc0 write ports
//   count/compare/timer_int   : registered timer state
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);
    logic tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick      <= 1'b0;
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            tick      <= ~tick;
            count     <= count_we ? wdata : count + {31'd0, tick};
            if (compare_we) compare <= wdata;
            // A Compare write acknowledges the interrupt and beats a same-cycle match.
            timer_int <= compare_we ? 1'b0 : (timer_int | (count == compare && compare != '0));
        end
    end
endmodule

// File: rtl/cp0_regs.sv
// cp0_regs: MIPS coprocessor-0 register file with exception update and timer.
//   clk, rst (async active-low)
//   we_i/waddr_i/data_i : mtc0 write;  raddr_i/data_o : mfc0 read (combinational)
//   int_i               : external interrupt lines
//   excepttype_i, pc_i, in_delayslot_i, bad_addr_i : exception from the decoder
//   count_o .. badvaddr_o, timer_int_o : registered CP0 state
module cp0_regs
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4220
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);
    // An exception in flight discards any mtc0 issued in the same cycle.
    logic        mtc0;
    logic [5:0]  ip_live;
    logic [31:0] status_wr, cause_live, cause_wr, rd_cur, wr_val;

    assign mtc0       = we_i && excepttype_i == '0;
    assign ip_live    = {int_i[5] | timer_int_o, int_i[4:0]};
    assign status_wr  = (status_o & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
    assign cause_live = {cause_o[31:16], ip_live, cause_o[9:0]};
    assign cause_wr   = (cause_live & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);

    cp0_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .count_we  (mtc0 && waddr_i == CP0_COUNT),
        .compare_we(mtc0 && waddr_i == CP0_COMPARE),
        .wdata     (data_i),
        .count     (count_o),
        .compare   (compare_o),
        .timer_int (timer_int_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_o   <= STATUS_RESET;
            cause_o    <= '0;
            epc_o      <= '0;
            badvaddr_o <= '0;
        end else begin
            cause_o[15:10] <= ip_live;
            if (is_trap(excepttype_i)) begin
                // A nested trap keeps the original return point.
                if (!status_o[1]) begin
                    epc_o       <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
                    cause_o[31] <= in_delayslot_i;
                end
                status_o[1]  <= 1'b1;
                cause_o[6:2] <= excepttype_i[4:0];
                if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES) badvaddr_o <= bad_addr_i;
            end else if (excepttype_i == EXC_ERET) begin
                status_o[1] <= 1'b0;
            end else if (mtc0) begin
                case (waddr_i)
                    CP0_STATUS: status_o     <= status_wr;
                    CP0_CAUSE:  cause_o[9:8] <= data_i[9:8];
                    CP0_EPC:    epc_o        <= data_i;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        rd_cur = '0;
        case (raddr_i)
            CP0_BADVADDR: rd_cur = badvaddr_o;
            CP0_COUNT:    rd_cur = count_o;
            CP0_COMPARE:  rd_cur = compare_o;
            CP0_STATUS:   rd_cur = status_o;
            CP0_CAUSE:    rd_cur = cause_live;
            CP0_EPC:      rd_cur = epc_o;
            CP0_PRID:     rd_cur = PRID_VALUE;
            default:      rd_cur = '0;
        endcase
    end

    // Value a same-address mtc0 would leave behind; read-only registers keep theirs.
    always_comb begin
        wr_val = rd_cur;
        case (raddr_i)
            CP0_COUNT, CP0_COMPARE, CP0_EPC: wr_val = data_i;
            CP0_STATUS:                      wr_val = status_wr;
            CP0_CAUSE:                       wr_val = cause_wr;
            default:                         wr_val = rd_cur;
        endcase
    end

    assign data_o = (we_i && waddr_i == raddr_i) ? wr_val : rd_cur;
endmodule

// File: doc/cp0_regs.md
# cp0_regs

Coprocessor-0 register file for the five-stage MIPS core. It sits directly downstream of the memory-stage exception decoder and consumes its `exceptiontype`, then updates Status/Cause/EPC/BadVAddr on the following clock edge. It also feeds `status_o`, `cause_o` and `epc_o` back to the decoder for the next interrupt check and `eret` target. It serves `mfc0`/`mtc0` accesses and runs the Count/Compare timer.

## Interface
- `PRID_VALUE`, 32'h0000_4220: read-only PRId contents.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous reset, active-low (rst=0 resets).
- `we_i`  in  1  mtc0 write enable.
- `waddr_i`  in  5  mtc0 register number.
- `raddr_i`  in  5  mfc0 register number.
- `data_i`  in  32  mtc0 write data.
- `int_i`  in  6  external hardware interrupt lines, level-sensitive.
- `excepttype_i`  in  32  exception code from decoder: 0, 1, 4, 5, 8, 9, a, c, e.
- `pc_i`  in  32  PC of the excepting instruction.
- `in_delayslot_i`  in  1  the excepting instruction is in a delay slot.
- `bad_addr_i`  in  32  faulting address for AdEL/AdES.
- `data_o`  out  32  mfc0 read data, combinational.
- `count_o`, `compare_o`, `status_o`, `cause_o`, `epc_o`, `badvaddr_o`  out  32 each  registered CP0 values.
- `timer_int_o`  out  1  timer interrupt pending.

## Operation
- **Registers:** BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15). Any other number reads 0; writes to it are ignored.
- **Reset values:** Status = 32'h0040_0000 (BEV=1). All other outputs = 0, `timer_int_o` = 0, and the half-rate tick flop = 0.
- **Writable bits:**
  - Status: [15:8] IM, [1] EXL, [0] IE. BEV stays 1.
  - Cause: [9:8] IP1..IP0 only.
  - BadVAddr and PRId are not writable by mtc0.
- **Count:**
  - The tick flop toggles every cycle. Count increments (wraps mod 2^32) on cycles where tick=1, i.e. at half the clock rate.
  - An mtc0 to Count loads `data_i` and suppresses that cycle's increment. The tick flop is unaffected.
- **Timer interrupt:**
  - When Count == Compare and Compare != 0, `timer_int_o` sets on the next edge.
  - An mtc0 to Compare loads Compare and clears `timer_int_o`. The clear wins over a same-cycle set.
- **Cause.IP[7:2]:** updated every cycle to {int_i[5] | timer_int_o, int_i[4:0]}.
- **Exception update (excepttype_i != 0), highest priority:**
  - When excepttype_i is in {1,4,5,8,9,a,c}:
    - If Status.EXL=0: EPC = in_delayslot_i ? pc_i−4 : pc_i, and Cause.BD = in_delayslot_i.
    - If EXL was already 1, EPC and BD are kept.
    - Then EXL=1 and Cause.ExcCode[6:2] = excepttype_i[4:0].
    - For types 4 and 5, BadVAddr additionally = bad_addr_i.
  - When excepttype_i = e (eret): Status.EXL=0. No other register changes.
  - Any same-cycle mtc0 is discarded. Count increment and IP sampling still occur.
- **Reads:**
  - `data_o` = the selected register.
  - If `we_i` is set with waddr_i == raddr_i, `data_o` returns the post-mask value being written (internal bypass).
  - raddr=13 always shows live IP bits.

## Timing
- All register updates happen at posedge `clk`; outputs are the flop values, so effects are visible one cycle after the inputs.
- `data_o` has zero latency (combinational from flops plus the bypass).
- The exception update lands on the edge that ends the cycle in which `excepttype_i` is presented. The decoder sees the new EXL on the next cycle, which masks re-entry.
- Asserting `rst` mid-operation immediately forces all reset values, with no clock required. Deassertion is expected to be synchronised upstream.

## Structure
- **Shared package `cp0_defs`:**
  - register numbers (CP0_BADVADDR, CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC, CP0_PRID);
  - exception codes (EXC_INT=1, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=a, EXC_OV=c, EXC_ERET=e);
  - STATUS_RESET and the Status/Cause write masks.
- **Sub-module `cp0_timer`:** holds the tick flop, Count, Compare and `timer_int_o`, with write ports for Count and Compare.

## Test plan
- Reset with rst=0 → status_o=0x0040_0000; all other outputs 0. After rst=1 for 8 cycles → count_o=4.
- mtc0 Compare=6, then run until Count=6 → `timer_int_o`=1 one cycle later and cause_o[15]=1. mtc0 Compare=0x20 → `timer_int_o`=0 next cycle.
- excepttype_i=4, pc_i=0xbfc0_0100, in_delayslot_i=1, bad_addr_i=0x1235 → epc_o=0xbfc0_00fc, cause_o[31]=1, ExcCode=4, badvaddr_o=0x1235, status_o[1]=1.
- With EXL=1, excepttype_i=8 at pc 0x8000_0000 → EPC unchanged, ExcCode=8. Then excepttype_i=e → status_o[1]=0.
- Same cycle: we_i=1 to EPC with data 0xdead_beef and excepttype_i=c → EPC gets pc_i, not 0xdead_beef.
- mtc0 Status=0xffff_ffff → status_o=0x0040_ff03. Same-cycle read of raddr=12 → data_o=0x0040_ff03.
